// File: rtl/divisor_frequencia_param_if.sv
// rtl/divisor_frequencia_param_if.sv - control/output bundle for the multi-channel frequency divider
interface divisor_frequencia_param_if #(
    parameter int WIDTH = 24,
    parameter int N_CH  = 2
);
    logic                    enable;
    logic                    sync_clear;
    logic [N_CH*WIDTH-1:0]   div_val;
    logic [N_CH-1:0]         tick;
    logic [N_CH-1:0]         wave;

    modport master (
        output enable,
        output sync_clear,
        output div_val,
        input  tick,
        input  wave
    );

    modport slave (
        input  enable,
        input  sync_clear,
        input  div_val,
        output tick,
        output wave
    );
endinterface

// File: rtl/divisor_frequencia_param.sv
// rtl/divisor_frequencia_param.sv - N_CH independent synchronous dividers producing tick enables and square waves
module divisor_frequencia_param #(
    parameter int WIDTH = 24,
    parameter int N_CH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    divisor_frequencia_param_if.slave    bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [N_CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0][WIDTH-1:0] div_act_q, div_act_d;
    logic [N_CH-1:0]            tick_q, tick_d;
    logic [N_CH-1:0]            wave_q, wave_d;

    logic [N_CH-1:0][WIDTH-1:0] div_in;
    logic [N_CH-1:0][WIDTH-1:0] d_eff;
    logic [N_CH-1:0]            wrap;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign div_in[g] = bus.div_val[g*WIDTH +: WIDTH];
        // A programmed ratio of zero behaves as divide-by-one.
        assign d_eff[g]  = (div_act_q[g] == '0) ? ONE : div_act_q[g];
        // >= keeps the counter bounded if the active ratio ever shrinks below it.
        assign wrap[g]   = (cnt_q[g] >= (d_eff[g] - ONE));
    end

    always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        tick_d    = '0;
        wave_d    = wave_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (bus.sync_clear) begin
                cnt_d[ch]  = '0;
                wave_d[ch] = 1'b0;
            end else if (bus.enable) begin
                if (wrap[ch]) begin
                    cnt_d[ch]     = '0;
                    tick_d[ch]    = 1'b1;
                    wave_d[ch]    = ~wave_q[ch];
                    div_act_d[ch] = div_in[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + ONE;
                end
            end
        end
    end

    // Reset reloads the active ratio so the first period already uses the programmed value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            div_act_q <= div_in;
            tick_q    <= '0;
            wave_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            tick_q    <= tick_d;
            wave_q    <= wave_d;
        end
    end

    assign bus.tick = tick_q;
    assign bus.wave = wave_q;
endmodule
